// File: rtl/scalar_lsu.sv
// Scalar load/store unit: one memory op at a time, request held until dmem_ready.
// Loads return as a one-cycle load_ready pulse; misaligned/illegal ops are dropped with misalign_err.
module scalar_lsu #(
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic              issue_is_store,
   input  logic [2:0]        issue_funct3,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [31:0]       issue_wdata,
   input  logic [REG_W-1:0]  issue_rd,
   output logic              dmem_ren,
   output logic              dmem_wen,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_byteen,
   output logic [31:0]       dmem_store,
   input  logic              dmem_ready,
   input  logic [31:0]       dmem_load,
   output logic              load_ready,
   output logic [31:0]       dmemload,
   output logic [REG_W-1:0]  reg_sel_load,
   output logic              misalign_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              ren_q, ren_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       st_q, st_d;
   logic [31:0]       ld_q, ld_d;
   logic [REG_W-1:0]  sel_q, sel_d;
   logic              err_q, err_d;
   logic              is_st_q, is_st_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lane_q, lane_d;
   logic [REG_W-1:0]  rd_q, rd_d;

   logic              acc_bad;
   logic [3:0]        be_calc;
   logic [31:0]       st_calc;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_ext;

   // Illegal encodings share the misalignment path so the op is dropped cleanly.
   always_comb begin
      acc_bad = 1'b1;
      case (issue_funct3)
         3'b000:  acc_bad = 1'b0;
         3'b001:  acc_bad = issue_addr[0];
         3'b010:  acc_bad = |issue_addr[1:0];
         3'b100:  acc_bad = issue_is_store;
         3'b101:  acc_bad = issue_is_store | issue_addr[0];
         default: acc_bad = 1'b1;
      endcase
   end

   always_comb begin
      be_calc = 4'b1111;
      st_calc = issue_wdata;
      case (issue_funct3[1:0])
         2'b00: begin
            be_calc = 4'b0001 << issue_addr[1:0];
            st_calc = {4{issue_wdata[7:0]}};
         end
         2'b01: begin
            be_calc = 4'b0011 << issue_addr[1:0];
            st_calc = {2{issue_wdata[15:0]}};
         end
         default: begin
            be_calc = 4'b1111;
            st_calc = issue_wdata;
         end
      endcase
   end

   // Little-endian lane select on the returned word, then sign/zero extension.
   always_comb begin
      ld_byte = dmem_load[{lane_q, 3'b000} +: 8];
      ld_half = dmem_load[{lane_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = dmem_load;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ren_d   = ren_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      be_d    = be_q;
      st_d    = st_q;
      ld_d    = ld_q;
      sel_d   = sel_q;
      err_d   = 1'b0;
      is_st_d = is_st_q;
      f3_d    = f3_q;
      lane_d  = lane_q;
      rd_d    = rd_q;
      case (state_q)
         S_IDLE: begin
            if (issue_valid) begin
               is_st_d = issue_is_store;
               f3_d    = issue_funct3;
               lane_d  = issue_addr[1:0];
               rd_d    = issue_rd;
               if (acc_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  ren_d   = ~issue_is_store;
                  wen_d   = issue_is_store;
                  addr_d  = {issue_addr[ADDR_W-1:2], 2'b00};
                  be_d    = be_calc;
                  st_d    = st_calc;
               end
            end
         end
         S_REQ: begin
            if (dmem_ready) begin
               ren_d = 1'b0;
               wen_d = 1'b0;
               if (is_st_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_RESP;
                  ld_d    = ld_ext;
                  sel_d   = rd_q;
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         st_q    <= 32'd0;
         ld_q    <= 32'd0;
         sel_q   <= '0;
         err_q   <= 1'b0;
         is_st_q <= 1'b0;
         f3_q    <= 3'b000;
         lane_q  <= 2'b00;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         st_q    <= st_d;
         ld_q    <= ld_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         is_st_q <= is_st_d;
         f3_q    <= f3_d;
         lane_q  <= lane_d;
         rd_q    <= rd_d;
      end
   end

   assign issue_ready  = (state_q == S_IDLE);
   assign load_ready   = (state_q == S_RESP);
   assign dmem_ren     = ren_q;
   assign dmem_wen     = wen_q;
   assign dmem_addr    = addr_q;
   assign dmem_byteen  = be_q;
   assign dmem_store   = st_q;
   assign dmemload     = ld_q;
   assign reg_sel_load = sel_q;
   assign misalign_err = err_q;

endmodule

// File: doc/scalar_lsu.md
# scalar_lsu

Scalar load/store unit for the tensor-core control pipeline. It sits directly upstream of the writeback unit. It accepts one decoded memory operation at a time and runs the request/ready handshake with data memory. Loads are sign- or zero-extended and returned to writeback as a one-cycle `load_ready` pulse with `dmemload` and `reg_sel_load`; stores complete without writeback.

## Interface
- `ADDR_W`, default 32: byte address width.
- `REG_W`, default 5: destination register index width.
- `CLK` in 1: single clock, all state on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `issue_valid` in 1: operation offered this cycle.
- `issue_ready` out 1: unit can accept; transfer occurs when `issue_valid && issue_ready`.
- `issue_is_store` in 1: 1 = store, 0 = load.
- `issue_funct3` in 3: size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only).
- `issue_addr` in ADDR_W: effective byte address (already base+imm).
- `issue_wdata` in 32: store data, in low bits.
- `issue_rd` in REG_W: load destination register.
- `dmem_ren` out 1: read request.
- `dmem_wen` out 1: write request.
- `dmem_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `dmem_byteen` out 4: byte lane enables.
- `dmem_store` out 32: lane-aligned store data.
- `dmem_ready` in 1: memory completes the request this cycle; `dmem_load` is valid in the same cycle.
- `dmem_load` in 32: read word.
- `load_ready` out 1: to writeback, one-cycle pulse.
- `dmemload` out 32: extended load result.
- `reg_sel_load` out REG_W: destination register.
- `misalign_err` out 1: one-cycle pulse, misaligned access dropped.

## Operation
- States: IDLE, REQ, RESP.
- `issue_ready` = (state == IDLE).
- IDLE:
  - On transfer, latch all `issue_*` fields.
  - Aligned: go to REQ.
  - Misaligned (H with addr[0]=1; W with addr[1:0]≠0): pulse `misalign_err` next cycle, stay IDLE, no memory access.
  - Illegal funct3 (011, 110, 111, or store 1xx) is treated as misaligned.
- REQ:
  - Assert `dmem_ren` or `dmem_wen` and hold `dmem_addr`, `dmem_byteen`, `dmem_store` stable until `dmem_ready`.
  - On `dmem_ready` for a load: latch `dmem_load` and go to RESP.
  - On `dmem_ready` for a store: go to IDLE.
- RESP: `load_ready`=1 for exactly this cycle with `dmemload`/`reg_sel_load`; go to IDLE.
- Byte enables, with lane = addr[1:0]:
  - B: `4'b0001 << lane`.
  - H: `4'b0011 << lane`.
  - W: `4'b1111`.
- Store data lanes:
  - B: byte replicated ×4.
  - H: halfword replicated ×2.
  - W: as-is.
- Load extraction (little-endian):
  - B/H: select the byte/halfword at the lane, then sign-extend.
  - BU/HU: same selection, zero-extended.
  - W: full word.
- Loads with `issue_rd`=0 still perform the access and pulse `load_ready`; writeback/regfile ignores x0.

## Timing
- Reset state:
  - State IDLE.
  - `issue_ready`=1.
  - `dmem_ren`, `dmem_wen`, `load_ready`, `misalign_err` = 0.
  - `dmem_addr`, `dmem_byteen`, `dmem_store`, `dmemload`, `reg_sel_load` = 0.
- Load latency:
  - Transfer at cycle 0; request visible cycle 1.
  - If `dmem_ready` arrives at cycle k≥1, `load_ready` is at k+1.
  - Next transfer is possible at cycle k+2.
- Store: `dmem_ready` at k means the next transfer is possible at k+1.
- Zero-wait memory (`dmem_ready` in the first REQ cycle):
  - Load occupies 3 cycles per op.
  - Store occupies 2 cycles per op.
- Misaligned op: `misalign_err` at cycle 1; the next transfer is possible at cycle 1.
- `dmem_ready` outside REQ is ignored.
- Request outputs are registered and change only on state entry.
- `load_ready` never overlaps an active request; writeback never sees back-to-back load pulses.
- Asynchronous reset asserted mid-REQ:
  - Request deasserts immediately.
  - The in-flight op is discarded; no `load_ready` or `misalign_err`.
  - The unit is IDLE when reset deasserts.

## Test plan
- LW at 0x100, rd=5, memory returns 0xDEADBEEF after 2 wait cycles -> `dmem_ren` held with addr 0x100 and byteen 1111 for 3 cycles; `load_ready`=1 for one cycle with `dmemload`=0xDEADBEEF and `reg_sel_load`=5.
- LB at 0x103 with word 0x80FF7F01:
  - -> byteen 1000, `dmemload`=0xFFFFFF80.
  - Repeat as LBU -> 0x00000080.
  - LH at 0x102 -> 0xFFFF80FF.
  - LHU -> 0x000080FF.
- SB 0xAB at 0x201 -> `dmem_wen`, addr 0x200, byteen 0010, `dmem_store`=0xABABABAB; no `load_ready`; `issue_ready` returns the cycle after `dmem_ready`.
- LW at 0x102 and SH at 0x301 -> `misalign_err` one-cycle pulse each; `dmem_ren`/`dmem_wen` never asserted; `issue_ready` stays 1.
- Back-to-back: `issue_valid` held high with LW, SW, LW and zero-wait memory -> transfers at cycles 0, 3, 5; exactly two `load_ready` pulses with correct rd values.
- `RST` asserted in the second REQ cycle of an LW -> `dmem_ren`=0 immediately; no `load_ready` afterward; after release, `issue_ready`=1 and a new LW completes normally.
